// File: rtl/h_code_21_16_pkg.sv
// Hamming (21,16) SEC-DED code constants and position helpers, shared by encoder and decoder.
package h_code_21_16_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CODE_W = 22;
   localparam int unsigned NPAR   = 5;

   localparam int unsigned PAR_POS [NPAR] = '{1, 2, 4, 8, 16};

   // Data bit idx lands on the idx-th non-power-of-two position in 1..21.
   function automatic int unsigned data_to_pos(input int unsigned idx);
      int unsigned pos = 0;
      int unsigned n   = 0;
      for (int unsigned p = 1; p < CODE_W; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (n == idx) pos = p;
            n++;
         end
      end
      return pos;
   endfunction

   // Data positions covered by the parity bit sitting at position ppos.
   function automatic logic [CODE_W-1:0] par_mask(input int unsigned ppos);
      logic [CODE_W-1:0] m = '0;
      for (int unsigned p = 1; p < CODE_W; p++) begin
         if (((p & ppos) != 0) && ((p & (p - 1)) != 0)) m = m | (CODE_W'(1) << p);
      end
      return m;
   endfunction

endpackage

// File: rtl/h_encoder_stream_21_16_if.sv
// Valid/ready stream bundle: 16-bit data words in, 22-bit codewords out.
interface h_encoder_stream_21_16_if;
   import h_code_21_16_pkg::*;

   logic              i_Valid;
   logic              o_Ready;
   logic [DATA_W-1:0] i_DataWord;
   logic              o_Valid;
   logic              i_Ready;
   logic [CODE_W-1:0] o_CodeWord;

   modport master (
      output i_Valid, i_DataWord, i_Ready,
      input  o_Ready, o_Valid, o_CodeWord
   );

   modport slave (
      input  i_Valid, i_DataWord, i_Ready,
      output o_Ready, o_Valid, o_CodeWord
   );

endinterface

// File: rtl/h_enc_core_21_16.sv
// Combinational Hamming (21,16) encoder: 5 even-parity bits plus overall parity in bit 0.
module h_enc_core_21_16
   import h_code_21_16_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [CODE_W-1:0] code
);

   logic [CODE_W-1:0] spread;

   always_comb begin
      spread = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         spread = spread | (CODE_W'(data[i]) << data_to_pos(i));
      end
      code = spread;
      for (int unsigned k = 0; k < NPAR; k++) begin
         code = code | (CODE_W'(^(spread & par_mask(PAR_POS[k]))) << PAR_POS[k]);
      end
      code[0] = ^code[CODE_W-1:1];
   end

endmodule

// File: rtl/h_encoder_stream_21_16.sv
// Streaming (21,16) SEC-DED encoder with a DEPTH-entry registered output buffer.
// Define H_ENC_ERR_INJ_EN to add the error-injection ports (i_InjEn, i_InjMask, o_InjCount).
module h_encoder_stream_21_16
   import h_code_21_16_pkg::*;
#(
   parameter int unsigned DEPTH = 2,  // 2 or 4
   parameter int unsigned CNT_W = 16
) (
   input  logic                 i_Clk,
   input  logic                 i_RstN,
   h_encoder_stream_21_16_if.slave bus,
   output logic                 o_Full,
   output logic [CNT_W-1:0]     o_WordCount
`ifdef H_ENC_ERR_INJ_EN
   ,
   input  logic                 i_InjEn,
   input  logic [CODE_W-1:0]    i_InjMask,
   output logic [7:0]           o_InjCount
`endif
);

   localparam int unsigned     PTR_W     = $clog2(DEPTH);
   localparam int unsigned     OCC_W     = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

   logic [CODE_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              ready_q;
   logic [CODE_W-1:0] last_q;
   logic [CNT_W-1:0]  word_cnt_q;
   logic [CODE_W-1:0] enc_word, store_word;
   logic              valid, push, pop;

   h_enc_core_21_16 u_core (
      .data (bus.i_DataWord),
      .code (enc_word)
   );

`ifdef H_ENC_ERR_INJ_EN
   logic [7:0] inj_cnt_q;

   assign store_word = i_InjEn ? (enc_word ^ i_InjMask) : enc_word;
   assign o_InjCount = inj_cnt_q;

   always_ff @(posedge i_Clk or negedge i_RstN) begin
      if (!i_RstN) begin
         inj_cnt_q <= '0;
      end else if (push && i_InjEn && (inj_cnt_q != 8'hFF)) begin
         inj_cnt_q <= inj_cnt_q + 8'd1;
      end
   end
`else
   assign store_word = enc_word;
`endif

   assign valid = (occ_q != '0);
   // ready_q is a flop, so downstream i_Ready never reaches o_Ready combinationally.
   assign push  = bus.i_Valid & ready_q;
   assign pop   = valid & bus.i_Ready;

   always_comb begin
      occ_d = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + 1'b1;
      end else if (pop && !push) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge i_Clk or negedge i_RstN) begin
      if (!i_RstN) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         ready_q    <= 1'b0;
         last_q     <= '0;
         word_cnt_q <= '0;
      end else begin
         occ_q   <= occ_d;
         ready_q <= (occ_d < DEPTH_OCC);
         if (push) begin
            wr_ptr_q   <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            word_cnt_q <= word_cnt_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            last_q   <= mem_q[rd_ptr_q];
         end
      end
   end

   // Storage needs no reset: it is only shown while occupancy is non-zero.
   always_ff @(posedge i_Clk) begin
      if (push) mem_q[wr_ptr_q] <= store_word;
   end

   assign bus.o_Ready    = ready_q;
   assign bus.o_Valid    = valid;
   assign bus.o_CodeWord = valid ? mem_q[rd_ptr_q] : last_q;
   assign o_Full         = (occ_q == DEPTH_OCC);
   assign o_WordCount    = word_cnt_q;

endmodule

// File: tb/tb_h_encoder_stream_21_16.sv
// Self-checking bench: vector table, order/backpressure sequences, random stream with scoreboard.
module tb_h_encoder_stream_21_16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic full;
   logic [15:0] word_count;
`ifdef H_ENC_ERR_INJ_EN
   logic        inj_en = 1'b0;
   logic [21:0] inj_mask = '0;
   logic [7:0]  inj_count;
`endif

   h_encoder_stream_21_16_if bus ();

   h_encoder_stream_21_16 #(.DEPTH(2), .CNT_W(16)) dut (
      .i_Clk       (clk),
      .i_RstN      (rst_n),
      .bus         (bus),
      .o_Full      (full),
      .o_WordCount (word_count)
`ifdef H_ENC_ERR_INJ_EN
      ,
      .i_InjEn     (inj_en),
      .i_InjMask   (inj_mask),
      .o_InjCount  (inj_count)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int acc_cnt = 0;
   int stalls = 0;
   bit in_stream = 1'b0;
   logic [21:0] sb_q[$];

   typedef struct {
      logic [15:0] data;
      logic [21:0] code;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [21:0] ref_enc(input logic [15:0] d);
      logic [21:0] cw = '0;
      logic par;
      cw[3]     = d[0];
      cw[7:5]   = d[3:1];
      cw[15:9]  = d[10:4];
      cw[21:17] = d[15:11];
      for (int k = 0; k < 5; k++) begin
         par = 1'b0;
         for (int p = 3; p < 22; p++) begin
            if ((((p >> k) & 1) == 1) && ((p & (p - 1)) != 0)) par ^= cw[p];
         end
         cw[1 << k] = par;
      end
      cw[0] = ^cw[21:1];
      return cw;
   endfunction

   // Scoreboard: pop/compare on emit, push model result on accept.
   always @(negedge clk) begin
      logic [21:0] exp;
      if (rst_n) begin
         if (bus.o_Valid && bus.i_Ready) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp = sb_q.pop_front();
               check("sb_codeword", 32'(bus.o_CodeWord), 32'(exp));
            end
         end
         if (bus.i_Valid && bus.o_Ready) begin
            exp = ref_enc(bus.i_DataWord);
`ifdef H_ENC_ERR_INJ_EN
            if (inj_en) exp = exp ^ inj_mask;
`endif
            sb_q.push_back(exp);
            acc_cnt++;
         end
         if (in_stream && bus.i_Valid && !bus.o_Ready) stalls++;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      sb_q.delete();
      acc_cnt = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [15:0] d);
      int n = 0;
      bus.i_Valid = 1'b1;
      bus.i_DataWord = d;
      while (!bus.o_Ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20) check("send_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.i_Valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h0001, 22'h00000F};
      vecs[1] = '{16'h8000, 22'h210012};
      vecs[2] = '{16'h0000, 22'h000000};
      vecs[3] = '{16'h0002, 22'h000033};
      vecs[4] = '{16'h0400, 22'h008117};
      vecs[5] = '{16'hFFFF, 22'h3FFFFC};

      bus.i_Valid = 1'b0;
      bus.i_DataWord = '0;
      bus.i_Ready = 1'b1;

      // Reset state
      #3;
      check("rst_valid", 32'(bus.o_Valid), 32'd0);
      check("rst_ready", 32'(bus.o_Ready), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_code", 32'(bus.o_CodeWord), 32'd0);
      check("rst_count", 32'(word_count), 32'd0);
      do_reset();

      // Table of known codewords, buffer empty so latency is one edge
      foreach (vecs[i]) begin
         send(vecs[i].data);
         @(negedge clk);
         check("vec_valid", 32'(bus.o_Valid), 32'd1);
         check("vec_code", 32'(bus.o_CodeWord), 32'(vecs[i].code));
         check("vec_count", 32'(word_count), 32'(acc_cnt));
         @(posedge clk);
         #1;
      end

      // Backpressure: fill, hold, then drain in order
      bus.i_Ready = 1'b0;
      send(16'h0001);
      send(16'h8000);
      @(negedge clk);
      check("full_flag", 32'(full), 32'd1);
      check("full_ready", 32'(bus.o_Ready), 32'd0);
      check("full_code", 32'(bus.o_CodeWord), 32'h00000F);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("hold_code", 32'(bus.o_CodeWord), 32'h00000F);
      @(posedge clk);
      #1 bus.i_Ready = 1'b1;
      @(negedge clk);
      check("drain_first", 32'(bus.o_CodeWord), 32'h00000F);
      @(negedge clk);
      check("drain_second", 32'(bus.o_CodeWord), 32'h210012);
      check("drain_ready", 32'(bus.o_Ready), 32'd1);
      @(negedge clk);
      check("empty_valid", 32'(bus.o_Valid), 32'd0);
      check("empty_hold", 32'(bus.o_CodeWord), 32'h210012);
      @(posedge clk);
      #1;

`ifdef H_ENC_ERR_INJ_EN
      inj_en = 1'b1;
      inj_mask = 22'h000008;
      send(16'h0001);
      inj_en = 1'b0;
      @(negedge clk);
      check("inj_code", 32'(bus.o_CodeWord), 32'h000007);
      check("inj_count", 32'(inj_count), 32'd1);
      @(posedge clk);
      #1;
`endif

      // Continuous random stream at one word per cycle
      do_reset();
      in_stream = 1'b1;
      bus.i_DataWord = 16'($urandom);
      bus.i_Valid = 1'b1;
      for (int i = 1; i <= 70000; i++) begin
         @(posedge clk);
         #1 bus.i_DataWord = 16'($urandom);
      end
      bus.i_Valid = 1'b0;
      in_stream = 1'b0;
      @(negedge clk);
      check("stream_stalls", 32'(stalls), 32'd0);
      check("stream_count", 32'(word_count), 32'd4464);
      for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(negedge clk);
      check("stream_drain", 32'(sb_q.size()), 32'd0);
      @(posedge clk);
      #1;

      // Asynchronous reset with a full buffer
      bus.i_Ready = 1'b0;
      send(16'h1234);
      send(16'hABCD);
      @(negedge clk);
      check("pre_rst_full", 32'(full), 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_valid", 32'(bus.o_Valid), 32'd0);
      check("async_count", 32'(word_count), 32'd0);
      check("async_full", 32'(full), 32'd0);
      check("async_ready", 32'(bus.o_Ready), 32'd0);
      sb_q.delete();
      acc_cnt = 0;
      bus.i_Ready = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(16'h0002);
      @(negedge clk);
      check("post_rst_valid", 32'(bus.o_Valid), 32'd1);
      check("post_rst_code", 32'(bus.o_CodeWord), 32'h000033);
      check("post_rst_count", 32'(word_count), 32'd1);
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
